// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// blank/dash patterns and the BCD-to-segment lookup table.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // Active-high {g,f,e,d,c,b,a}; non-decimal codes render as a dash.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high a..g segment decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[code];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment display driver with shadowed BCD content,
// leading-zero blanking, per-digit blink and an anti-ghosting blank window.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYC      = 2000,
    parameter int BLINK_TICKS    = 250,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lead_zero,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PRE_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic                    scan_tick;
    logic [3:0]              cur_code;
    logic [6:0]              cur_glyph;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    lead_blank;
    logic                    full_blank;

    assign scan_tick = (prescaler_q == PRE_W'(SCAN_DIV - 1));

    always_comb begin
        prescaler_d   = prescaler_q + 1'b1;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (scan_tick) begin
            prescaler_d = '0;
            idx_d       = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bcd_d = bcd_q;
        dp_d  = dp_q;
        if (load) begin
            bcd_d = bcd_in;
            dp_d  = dp_in;
        end
    end

    // lead_zero[j]: every digit at or left of j is disabled or holds zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            run          = run & (~digit_en[j] | (bcd_q[4*j +: 4] == 4'd0));
            lead_zero[j] = run;
        end
    end

    assign cur_code = bcd_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .code (cur_code),
        .seg  (cur_glyph)
    );

    assign lead_blank = blank_lead_zero & (idx_q != '0) & lead_zero[idx_q];
    assign full_blank = ~digit_en[idx_q]
                      | (blink_mask[idx_q] & blink_phase_q)
                      | (prescaler_q < PRE_W'(BLANK_CYC));

    always_comb begin
        seg_d = SEG_OFF;
        sel_d = '0;
        if (!full_blank) begin
            seg_d[SEG_DP]      = dp_q[idx_q];
            seg_d[SEG_G:SEG_A] = lead_blank ? SEG_OFF[SEG_G:SEG_A] : cur_glyph;
            sel_d[idx_q]       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q   <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            bcd_q         <= '0;
            dp_q          <= '0;
            seg_q         <= SEG_OFF;
            sel_q         <= '0;
        end else begin
            prescaler_q   <= prescaler_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            bcd_q         <= bcd_d;
            dp_q          <= dp_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
        end
    end

    assign seg       = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign digit_sel = sel_q ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-digit, 8-cycle-slot configuration.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  blink_mask = '0;
    logic        blank_lead_zero = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  digit_sel;

    int vectors = 0;
    int miscompares = 0;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (8),
        .BLANK_CYC      (2),
        .BLINK_TICKS    (2),
        .SEG_ACTIVE_LOW (1'b0),
        .SEL_ACTIVE_LOW (1'b0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (load),
        .bcd_in          (bcd_in),
        .dp_in           (dp_in),
        .digit_en        (digit_en),
        .blink_mask      (blink_mask),
        .blank_lead_zero (blank_lead_zero),
        .seg             (seg),
        .digit_sel       (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp_sel, input logic [7:0] exp_seg);
        vectors++;
        assert (digit_sel === exp_sel)
        else begin
            miscompares++;
            $error("FAIL %s digit_sel got %b expected %b", tag, digit_sel, exp_sel);
        end
        vectors++;
        assert (seg === exp_seg)
        else begin
            miscompares++;
            $error("FAIL %s seg got %h expected %h", tag, seg, exp_seg);
        end
        vectors++;
        assert ($onehot0(digit_sel))
        else begin
            miscompares++;
            $error("FAIL %s onehot digit_sel got %b expected at most one bit", tag, digit_sel);
        end
    endtask

    // One 32-cycle frame starting at slot 0, prescaler 0. segs = {d3,d2,d1,d0};
    // lit marks digits that are neither disabled nor in a blink-dark phase.
    task automatic check_frame(input string tag, input logic [31:0] segs, input logic [3:0] lit);
        for (int c = 0; c < 32; c++) begin
            int slot;
            int p;
            logic [3:0] es;
            logic [7:0] eg;
            @(posedge clk);
            #1;
            load = 1'b0;
            slot = c / 8;
            p    = c % 8;
            es   = 4'b0000;
            eg   = 8'h00;
            if (p >= 2 && lit[slot]) begin
                es       = 4'b0000;
                es[slot] = 1'b1;
                eg       = segs[slot*8 +: 8];
            end
            check($sformatf("%s c%0d", tag, c), es, eg);
        end
    endtask

    initial begin
        // Reset state before any clock edge
        #2;
        check("reset", 4'b0000, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_clocked", 4'b0000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run, shadow zero, no blanking
        check_frame("free0", {8'h3F, 8'h3F, 8'h3F, 8'h3F}, 4'b1111);
        check_frame("free1", {8'h3F, 8'h3F, 8'h3F, 8'h3F}, 4'b1111);

        // 0123 with dp on digit 1 and leading-zero suppression
        bcd_in = 16'h0123; dp_in = 4'b0010; blank_lead_zero = 1'b1; load = 1'b1;
        check_frame("lz0123", {8'h00, 8'h06, 8'hDB, 8'h4F}, 4'b1111);

        bcd_in = 16'h000A; dp_in = 4'b0000; load = 1'b1;
        check_frame("dash", {8'h00, 8'h00, 8'h00, 8'h40}, 4'b1111);

        bcd_in = 16'h0000; load = 1'b1;
        check_frame("allzero", {8'h00, 8'h00, 8'h00, 8'h3F}, 4'b1111);

        // Disabled digit 3 counts as a leading zero for digit 2
        digit_en = 4'b0111; bcd_in = 16'h5000; load = 1'b1;
        check_frame("disabled", {8'h00, 8'h00, 8'h00, 8'h3F}, 4'b0111);

        // Blink phase is 0 during slots 0,1 and 1 during slots 2,3 of each frame
        digit_en = 4'hF; blank_lead_zero = 1'b0; bcd_in = 16'h4321; load = 1'b1;
        blink_mask = 4'b0101;
        check_frame("blink0101", {8'h66, 8'h4F, 8'h5B, 8'h06}, 4'b1011);
        blink_mask = 4'b1000;
        check_frame("blink1000", {8'h66, 8'h4F, 8'h5B, 8'h06}, 4'b0111);
        blink_mask = 4'b0000;

        // Asynchronous reset mid-slot at digit 2
        for (int c = 0; c <= 20; c++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_d2", 4'b0100, 8'h4F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 4'b0000, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", 4'b0000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("post_rst", {8'h3F, 8'h3F, 8'h3F, 8'h3F}, 4'b1111);

        // Load held high: shadow follows bcd_in one cycle late
        bcd_in = 16'h1111; load = 1'b1;
        for (int c = 0; c < 32; c++) begin
            int slot;
            logic [3:0] es;
            logic [7:0] eg;
            @(posedge clk);
            #1;
            slot = c / 8;
            es   = 4'b0000;
            eg   = 8'h00;
            if (c % 8 >= 2) begin
                es[slot] = 1'b1;
                eg       = (c < 4) ? 8'h06 : 8'h5B;
            end
            check($sformatf("held c%0d", c), es, eg);
            if (c == 2) bcd_in = 16'h2222;
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
